ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. LED set 0xED, reset 0xFF) to the keyboard over the same clock/data lines the keyboard receiver listens on.
- Implements the full sequence: inhibit, request-to-send, 8 data bits LSB first, odd parity, stop, device ACK.
- Drives the lines open-drain through active-high pull-low enables; the board top-level builds the tristate buffers.
- Asserts `busy` so the receiver path can ignore the bus during a transfer.

Parameters:
- INHIBIT_CYCLES, 5000, clk cycles ps2 clock is held low before RTS (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, max clk cycles from clock release to ACK completion (15 ms at 50 MHz).
- FILTER_LEN, 8, consecutive equal samples required to change the filtered ps2 clock level.

Ports:
- clk  in  1  system clock
- ar  in  1  asynchronous active-low reset
- ps2_clk_in  in  1  raw ps2 clock line level
- ps2_dat_in  in  1  raw ps2 data line level
- ps2_clk_low  out  1  1 = pull ps2 clock low, 0 = release
- ps2_dat_low  out  1  1 = pull ps2 data low, 0 = release
- tx_data  in  8  byte to send
- tx_valid  in  1  request; accepted when tx_ready=1
- tx_ready  out  1  high only in IDLE
- busy  out  1  high in every state except IDLE
- tx_done  out  1  one-cycle pulse: ACK received, lines idle
- tx_err  out  1  one-cycle pulse: timeout or missing ACK

Behaviour:
- Reset (ar=0, async): state=IDLE, both *_low=0, tx_ready=1, busy=0, tx_done=0, tx_err=0, counters=0, filtered clock=1.
- Input conditioning:
  - both raw lines pass through a 2-flop synchronizer;
  - clock then passes a FILTER_LEN shift filter (level changes only after FILTER_LEN equal samples);
  - fall = filtered clock 1->0, detected in the clk domain.
- Handshake: tx_valid && tx_ready in cycle N → tx_data latched; parity = ~^tx_data; state INHIBIT at N+1; tx_ready low from N+1. tx_valid while not ready is ignored (not queued).
- INHIBIT: ps2_clk_low=1, ps2_dat_low=0 for exactly INHIBIT_CYCLES cycles.
- RTS (1 cycle): ps2_dat_low=1 (start bit), ps2_clk_low=0; timeout counter cleared; go to SEND with bit index 0.
- SEND: on each fall, drive the next bit (ps2_dat_low = ~bit):
  - falls 1–8: data bits 0..7;
  - fall 9: parity;
  - fall 10: ps2_dat_low=0 (stop; released); go to ACK.
- ACK:
  - on the next fall, sample synced data; 0 → WAIT_IDLE, 1 → ERR;
  - WAIT_IDLE: wait until filtered clock=1 and synced data=1, then DONE.
- DONE: tx_done=1 for 1 cycle → IDLE.
- ERR: both *_low=0, tx_err=1 for 1 cycle → IDLE.
- Timeout: counter runs in RTS/SEND/ACK/WAIT_IDLE; reaching TIMEOUT_CYCLES → ERR from any of these states, lines released the same cycle.
- ps2_clk_low is 1 only in INHIBIT; ps2_dat_low is never 1 in IDLE, DONE or ERR.
- tx_done and tx_err are never high together; exactly one pulses per accepted request.
- Reset mid-transfer releases both lines immediately; no done/err pulse.
- Reset overrides a tx_valid arriving in the same cycle.

Test Plan (INHIBIT_CYCLES=16, TIMEOUT_CYCLES=2000, FILTER_LEN=4; bench models the keyboard, clock period 40 clk):
- Send 0xED, device ACKs → ps2_clk_low high exactly 16 cycles; then sampled bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done one pulse; busy falls with it; tx_err stays 0.
- Send 0x00 → parity bit 1; send 0x01 → parity bit 0; both complete with tx_done.
- Device never clocks after RTS → tx_err pulse 2000 cycles after RTS; both *_low=0 from that cycle; tx_ready=1 next cycle.
- Device clocks 11 times but leaves data high at the ACK fall → tx_err pulse, no tx_done.
- tx_valid held high with 0x55 during an active 0xFF transfer → only 0xFF is sent; 0x55 is accepted only after tx_ready returns.
- ar pulsed low during the 5th data bit → ps2_clk_low=ps2_dat_low=0 immediately; no pulses; next 0xF4 request completes normally.
- 1-cycle glitches (width <4) on ps2_clk_in during SEND → no extra bit advance; byte still correct.

Source files
------------

// File: rtl/ps2_host_tx.sv
//------------------------------------------------------------------------------
// Module      : ps2_host_tx
// Description : PS/2 host-to-device command transmitter (open-drain enables).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       ar,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_low,
    output logic       ps2_dat_low,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] C_INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  C_TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
    } state_t;

    state_t                r_state, w_next;
    logic                  r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic [FILTER_LEN-1:0] r_clk_hist;
    logic                  r_clk_filt, r_clk_filt_d;
    logic [7:0]            r_data;
    logic                  r_parity;
    logic [3:0]            r_bit_idx;
    logic                  r_dat_low;
    logic [INH_W-1:0]      r_inh_cnt;
    logic [TO_W-1:0]       r_to_cnt;
    logic                  w_fall, w_timed, w_timeout;

    // Synchronizers plus a run-length filter on the clock line; the filtered
    // level only flips once the whole history window agrees.
    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            r_clk_s1     <= 1'b1;
            r_clk_s2     <= 1'b1;
            r_dat_s1     <= 1'b1;
            r_dat_s2     <= 1'b1;
            r_clk_hist   <= '1;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
        end else begin
            r_clk_s1     <= ps2_clk_in;
            r_clk_s2     <= r_clk_s1;
            r_dat_s1     <= ps2_dat_in;
            r_dat_s2     <= r_dat_s1;
            r_clk_hist   <= {r_clk_hist[FILTER_LEN-2:0], r_clk_s2};
            r_clk_filt_d <= r_clk_filt;
            if (&r_clk_hist) begin
                r_clk_filt <= 1'b1;
            end else if (~|r_clk_hist) begin
                r_clk_filt <= 1'b0;
            end
        end
    end

    assign w_fall    = r_clk_filt_d & ~r_clk_filt;
    assign w_timed   = (r_state == S_RTS) || (r_state == S_SEND) ||
                       (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
    assign w_timeout = w_timed && (r_to_cnt == C_TO_LAST);

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        tx_ready    = 1'b0;
        busy        = 1'b1;
        tx_done     = 1'b0;
        tx_err      = 1'b0;
        ps2_clk_low = 1'b0;
        ps2_dat_low = 1'b0;
        case (r_state)
            S_IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
                if (tx_valid) w_next = S_INHIBIT;
            end
            S_INHIBIT: begin
                ps2_clk_low = 1'b1;
                if (r_inh_cnt == C_INH_LAST) w_next = S_RTS;
            end
            S_RTS: begin
                ps2_dat_low = 1'b1;
                w_next      = S_SEND;
            end
            S_SEND: begin
                ps2_dat_low = r_dat_low;
                if (w_fall && (r_bit_idx == 4'd9)) w_next = S_ACK;
            end
            S_ACK: begin
                if (w_fall) w_next = r_dat_s2 ? S_ERR : S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (r_clk_filt && r_dat_s2) w_next = S_DONE;
            end
            S_DONE: begin
                tx_done = 1'b1;
                w_next  = S_IDLE;
            end
            S_ERR: begin
                tx_err = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_timeout) w_next = S_ERR;
    end

    // The timeout counter holds at zero through INHIBIT, so it reads zero in
    // the RTS cycle and equals the number of cycles elapsed since RTS after.
    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            r_data    <= '0;
            r_parity  <= 1'b0;
            r_bit_idx <= '0;
            r_dat_low <= 1'b0;
            r_inh_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (tx_valid) begin
                        r_data    <= tx_data;
                        r_parity  <= ~^tx_data;
                        r_inh_cnt <= '0;
                        r_to_cnt  <= '0;
                    end
                end
                S_INHIBIT: begin
                    r_inh_cnt <= r_inh_cnt + 1'b1;
                    r_to_cnt  <= '0;
                end
                S_RTS: begin
                    r_bit_idx <= '0;
                    r_dat_low <= 1'b1;
                    r_to_cnt  <= r_to_cnt + 1'b1;
                end
                S_SEND: begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                    if (w_fall) begin
                        if (r_bit_idx < 4'd8) begin
                            r_dat_low <= ~r_data[r_bit_idx[2:0]];
                        end else if (r_bit_idx == 4'd8) begin
                            r_dat_low <= ~r_parity;
                        end else begin
                            r_dat_low <= 1'b0;
                        end
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end
                end
                S_ACK, S_WAIT_IDLE: begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire
